// File: rtl/vector_map_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_map_sequencer_if
// Purpose  : Input, function-unit and output channels of the vector map
//            sequencer grouped into one bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface vector_map_sequencer_if #(
    parameter int ELEM_W = 4,
    parameter int N      = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N*ELEM_W-1:0]   in_vector;
    logic                  fu_req_valid;
    logic                  fu_req_ready;
    logic [ELEM_W-1:0]     fu_req_data;
    logic                  fu_rsp_valid;
    logic [ELEM_W-1:0]     fu_rsp_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*ELEM_W-1:0]   out_vector;
    logic                  err;

    // The environment (producer, function unit, consumer) drives the master side.
    modport master (
        output in_valid, in_vector, fu_req_ready, fu_rsp_valid, fu_rsp_data, out_ready,
        input  in_ready, fu_req_valid, fu_req_data, out_valid, out_vector, err
    );

    modport slave (
        input  in_valid, in_vector, fu_req_ready, fu_rsp_valid, fu_rsp_data, out_ready,
        output in_ready, fu_req_valid, fu_req_data, out_valid, out_vector, err
    );
endinterface
`default_nettype wire

// File: rtl/vector_map_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_map_sequencer
// Purpose  : Streams each element of a captured vector through a shared
//            function unit and collects the in-order results into a vector.
// Revision : 1.0 - initial release
// ============================================================================
module vector_map_sequencer #(
    parameter int ELEM_W = 4,
    parameter int N      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vector_map_sequencer_if.slave bus
);
    localparam int                VEC_W   = N * ELEM_W;
    localparam int                IDX_W   = $clog2(N + 1);
    localparam logic [IDX_W-1:0]  END_IDX = IDX_W'(N);
    localparam logic [IDX_W-1:0]  ONE_IDX = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    issue_idx_q, issue_idx_d;
    logic [IDX_W-1:0]    collect_idx_q, collect_idx_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [VEC_W-1:0]    res_q, res_d;
    logic                err_q, err_d;
    logic                in_ready_q, in_ready_d;

    logic                req_valid;
    logic [ELEM_W-1:0]   req_data;
    logic                issue_fire;
    logic                rsp_accept;

    always_comb begin
        req_valid = (state_q == RUN) && (issue_idx_q < END_IDX);
        req_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (issue_idx_q == IDX_W'(k)) begin
                req_data = vec_q[k*ELEM_W +: ELEM_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        issue_idx_d   = issue_idx_q;
        collect_idx_d = collect_idx_q;
        vec_d         = vec_q;
        res_d         = res_q;
        err_d         = err_q;

        issue_fire = req_valid && bus.fu_req_ready;
        if (issue_fire) begin
            issue_idx_d = issue_idx_q + ONE_IDX;
        end

        // Compare against the post-issue count so a zero-latency response
        // to this cycle's request is accepted.
        rsp_accept = bus.fu_rsp_valid && (state_q == RUN) && (collect_idx_q < issue_idx_d);
        if (bus.fu_rsp_valid && !rsp_accept) begin
            err_d = 1'b1;
        end
        if (rsp_accept) begin
            collect_idx_d = collect_idx_q + ONE_IDX;
            for (int k = 0; k < N; k++) begin
                if (collect_idx_q == IDX_W'(k)) begin
                    res_d[k*ELEM_W +: ELEM_W] = bus.fu_rsp_data;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    vec_d         = bus.in_vector;
                    issue_idx_d   = '0;
                    collect_idx_d = '0;
                    state_d       = RUN;
                end
            end
            RUN: begin
                if (collect_idx_d == END_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            issue_idx_q   <= '0;
            collect_idx_q <= '0;
            vec_q         <= '0;
            res_q         <= '0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_idx_q   <= issue_idx_d;
            collect_idx_q <= collect_idx_d;
            vec_q         <= vec_d;
            res_q         <= res_d;
            err_q         <= err_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.fu_req_valid = req_valid;
    assign bus.fu_req_data  = req_data;
    assign bus.out_valid    = (state_q == DONE);
    assign bus.out_vector   = res_q;
    assign bus.err          = err_q;
endmodule
`default_nettype wire

// File: tb/tb_vector_map_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_map_sequencer
// Purpose  : Directed self-checking bench for vector_map_sequencer with an
//            add-one function unit of selectable 0- or 1-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_map_sequencer;
    localparam int ELEM_W = 4;
    localparam int N      = 5;
    localparam int VEC_W  = N * ELEM_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_map_sequencer_if #(.ELEM_W(ELEM_W), .N(N)) bus ();

    vector_map_sequencer #(.ELEM_W(ELEM_W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Add-one function unit; fu_lat0 selects combinational response.
    logic              fu_lat0 = 1'b0;
    logic              spur    = 1'b0;
    logic              d1_v    = 1'b0;
    logic [ELEM_W-1:0] d1_d    = '0;
    always @(posedge clk) begin
        d1_v <= bus.fu_req_valid && bus.fu_req_ready;
        d1_d <= bus.fu_req_data + 4'd1;
    end
    assign bus.fu_rsp_valid = spur || (fu_lat0 ? (bus.fu_req_valid && bus.fu_req_ready) : d1_v);
    assign bus.fu_rsp_data  = fu_lat0 ? (bus.fu_req_data + 4'd1) : d1_d;

    int n_vec = 0;
    int n_err = 0;

    task automatic send_vector(input logic [VEC_W-1:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            bus.in_valid  = 1'b1;
            bus.in_vector = v;
            @(negedge clk);
            bus.in_valid  = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
        n_vec++; if (bus.fu_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_fu_req_valid: got %b expected 0", bus.fu_req_valid); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", bus.err); end
        n_vec++; if (bus.out_vector !== 20'h00000) begin n_err++; $display("FAIL rst_out_vector: got %h expected 00000", bus.out_vector); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bit ok; int ov; logic [VEC_W-1:0] got;
        fu_lat0 = 1'b0; ov = 0; got = '0;
        send_vector(20'h54321, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_accept: got timeout expected in_ready"); end
        for (int c = 0; c < 30; c++) begin
            if (bus.out_valid) begin ov++; got = bus.out_vector; end
            @(negedge clk);
        end
        n_vec++; if (ov !== 1) begin n_err++; $display("FAIL basic_out_valid_cycles: got %0d expected 1", ov); end
        n_vec++; if (got !== 20'h65432) begin n_err++; $display("FAIL basic_out_vector: got %h expected 65432", got); end
        n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_zero_latency();
        bit ok;
        fu_lat0 = 1'b1;
        send_vector(20'hE9073, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL zl_accept: got timeout expected in_ready"); end
        for (int c = 1; c <= 6; c++) begin
            n_vec++;
            if (bus.fu_req_valid !== (c <= 5)) begin
                n_err++; $display("FAIL zl_fu_req_valid_c%0d: got %b expected %b", c, bus.fu_req_valid, (c <= 5));
            end
            if (c == 6) begin
                n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL zl_out_valid_c6: got %b expected 1", bus.out_valid); end
                n_vec++; if (bus.out_vector !== 20'hFA184) begin n_err++; $display("FAIL zl_out_vector: got %h expected fa184", bus.out_vector); end
            end
            @(negedge clk);
        end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL zl_in_ready_after: got %b expected 1", bus.in_ready); end
        fu_lat0 = 1'b0;
    endtask

    task automatic test_stall();
        bit ok; bit stalled; bit seen; int n_iss;
        logic [ELEM_W-1:0] held; logic [ELEM_W-1:0] exp_d; logic [VEC_W-1:0] got;
        fu_lat0 = 1'b0; stalled = 1'b0; seen = 1'b0; n_iss = 0; held = '0; got = '0;
        send_vector(20'h12345, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL stall_accept: got timeout expected in_ready"); end
        for (int c = 0; c < 40 && !seen; c++) begin
            bus.fu_req_ready = (c % 2 == 0);
            if (stalled && bus.fu_req_valid) begin
                n_vec++; if (bus.fu_req_data !== held) begin n_err++; $display("FAIL stall_hold: got %h expected %h", bus.fu_req_data, held); end
            end
            stalled = 1'b0;
            if (bus.fu_req_valid) begin
                if (bus.fu_req_ready) begin
                    exp_d = 4'(5 - n_iss);
                    n_vec++; if (bus.fu_req_data !== exp_d) begin n_err++; $display("FAIL stall_issue%0d: got %h expected %h", n_iss, bus.fu_req_data, exp_d); end
                    n_iss++;
                end else begin
                    stalled = 1'b1; held = bus.fu_req_data;
                end
            end
            if (bus.out_valid) begin seen = 1'b1; got = bus.out_vector; end
            @(negedge clk);
        end
        bus.fu_req_ready = 1'b1;
        n_vec++; if (n_iss !== 5) begin n_err++; $display("FAIL stall_issue_count: got %0d expected 5", n_iss); end
        n_vec++; if (got !== 20'h23456) begin n_err++; $display("FAIL stall_out_vector: got %h expected 23456 (seen=%b)", got, seen); end
    endtask

    task automatic test_backpressure();
        bit ok; bit seen;
        fu_lat0 = 1'b1; bus.out_ready = 1'b0; seen = 1'b0;
        send_vector(20'h00000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_accept: got timeout expected in_ready"); end
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL bp_done: got timeout expected out_valid"); end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if ({bus.out_valid, bus.in_ready, bus.out_vector} !== {1'b1, 1'b0, 20'h11111}) begin
                n_err++; $display("FAIL bp_hold%0d: got v=%b r=%b %h expected v=1 r=0 11111", i, bus.out_valid, bus.in_ready, bus.out_vector);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid); end
        fu_lat0 = 1'b0;
    endtask

    task automatic test_wrap_and_spurious();
        bit ok; bit seen; logic [VEC_W-1:0] got;
        seen = 1'b0; got = '0;
        send_vector(20'hFFFF3, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_accept: got timeout expected in_ready"); end
        for (int c = 0; c < 30 && !seen; c++) begin
            if (bus.out_valid) begin seen = 1'b1; got = bus.out_vector; end
            @(negedge clk);
        end
        n_vec++; if (got !== 20'h00004) begin n_err++; $display("FAIL wrap_out_vector: got %h expected 00004 (seen=%b)", got, seen); end
        n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL wrap_err: got %b expected 0", bus.err); end
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL spur_err: got %b expected 1", bus.err); end
        repeat (3) @(negedge clk);
        n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL spur_err_sticky: got %b expected 1", bus.err); end
    endtask

    task automatic test_mid_reset();
        bit ok; bit seen; logic [VEC_W-1:0] got;
        seen = 1'b0; got = '0;
        send_vector(20'hABCDE, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mr_accept: got timeout expected in_ready"); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.in_ready, bus.fu_req_valid, bus.out_valid, bus.err, bus.out_vector} !== {4'b0000, 20'h00000}) begin
            n_err++; $display("FAIL mr_reset_outputs: got r=%b fv=%b ov=%b e=%b %h expected all zero",
                              bus.in_ready, bus.fu_req_valid, bus.out_valid, bus.err, bus.out_vector);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mr_release_in_ready: got %b expected 1", bus.in_ready); end
        send_vector(20'h13579, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mr_accept2: got timeout expected in_ready"); end
        for (int c = 0; c < 30 && !seen; c++) begin
            if (bus.out_valid) begin seen = 1'b1; got = bus.out_vector; end
            @(negedge clk);
        end
        n_vec++; if (got !== 20'h2468A) begin n_err++; $display("FAIL mr_out_vector: got %h expected 2468a (seen=%b)", got, seen); end
        n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL mr_err: got %b expected 0", bus.err); end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_vector    = '0;
        bus.fu_req_ready = 1'b1;
        bus.out_ready    = 1'b1;
        test_reset();
        test_basic();
        test_zero_latency();
        test_stall();
        test_backpressure();
        test_wrap_and_spurious();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/vector_map_sequencer.md
VECTOR_MAP_SEQUENCER -- requirements
Module: vector_map_sequencer

Interface
REQ-001 SHALL have parameter ELEM_W, default 4, giving element width in bits.
REQ-002 SHALL have parameter N, default 5, giving elements per vector (N >= 1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  input vector offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an input vector.
REQ-007 SHALL have port in_vector  input  N*ELEM_W  input vector; element k at bits [k*ELEM_W +: ELEM_W].
REQ-008 SHALL have port fu_req_valid  output  1  element offered to the shared function unit.
REQ-009 SHALL have port fu_req_ready  input  1  function unit accepts the element.
REQ-010 SHALL have port fu_req_data  output  ELEM_W  element sent to the function unit.
REQ-011 SHALL have port fu_rsp_valid  input  1  function unit result present; no backpressure.
REQ-012 SHALL have port fu_rsp_data  input  ELEM_W  function unit result.
REQ-013 SHALL have port out_valid  output  1  mapped vector available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the mapped vector.
REQ-015 SHALL have port out_vector  output  N*ELEM_W  mapped vector, same element layout as in_vector.
REQ-016 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL implement the states IDLE, RUN, and DONE.
REQ-018 SHALL assert in_ready only in IDLE; an in_valid&&in_ready cycle SHALL capture in_vector, clear both indices, and enter RUN on the next edge.
REQ-019 SHALL in RUN drive fu_req_valid=1 while issue_idx<N, with fu_req_data = captured element issue_idx.
REQ-020 SHALL increment issue_idx on each fu_req_valid&&fu_req_ready cycle.
REQ-021 SHALL hold fu_req_data stable while fu_req_valid=1 and fu_req_ready=0.
REQ-022 SHALL drive fu_req_valid=0 once issue_idx=N.
REQ-023 SHALL accept function unit results in order: on fu_rsp_valid with collect_idx<issue_idx, write fu_rsp_data to result slot collect_idx and increment collect_idx.
REQ-024 SHALL support any function unit latency of 0 or more cycles, with any number outstanding up to N; an issue and a response in the same cycle SHALL both take effect.
REQ-025 SHALL ignore a response arriving when collect_idx=issue_idx, or in any state other than RUN, and set err=1 until reset.
REQ-026 SHALL enter DONE on the edge at which collect_idx becomes N; out_valid=1 in DONE only.
REQ-027 SHALL present the result slots on out_vector and hold them stable while out_valid=1.
REQ-028 SHALL in DONE, on out_valid&&out_ready, return to IDLE so that in_ready=1 on the next cycle; there is no IDLE bypass.
REQ-029 SHALL store results truncated to ELEM_W bits, with no saturation.
REQ-030 SHALL size both indices to hold 0..N inclusive.

Reset
REQ-031 SHALL on rst_n=0 immediately force state=IDLE, in_ready=0 during reset then 1 after release, fu_req_valid=0, out_valid=0, err=0, indices=0, result slots=0, and out_vector=0.
REQ-032 SHALL abandon any transaction in progress when reset is asserted mid-operation; responses still in flight after release SHALL set err per REQ-025.

Verification
REQ-033 SHALL be checked with in_vector {1,2,3,4,5}, a function unit that adds 1 with 1-cycle latency, fu_req_ready=1, and out_ready=1 -> out_vector {2,3,4,5,6}, out_valid high exactly one cycle, err=0.
REQ-034 SHALL be checked with a 0-latency function unit and input accepted at cycle 0 -> fu_req_valid high on cycles 1-5, out_valid=1 at cycle 6.
REQ-035 SHALL be checked with fu_req_ready toggling 1,0,1,0 -> fu_req_data unchanged across stalls, each element issued exactly once, results in order.
REQ-036 SHALL be checked with out_ready=0 for 10 cycles in DONE -> out_valid and out_vector held, in_ready=0, and in_ready=1 the cycle after out_ready rises.
REQ-037 SHALL be checked with element 15 through the add-1 unit -> result slot 0; and with a spurious fu_rsp_valid in IDLE -> err=1 and held.
REQ-038 SHALL be checked with rst_n pulsed low after 2 elements issued -> all outputs at reset values, then a new vector completes correctly.
